// File: rtl/dsp_mac_sequencer.sv
// Control stage for a DSP48E1 multiply-accumulate slice: term stream in, dot products out.
// Define DSP_MAC_SAT_EN to saturate results to OUT_W bits and flag clipping on m_ovf.
module dsp_mac_sequencer #(
  parameter int LAT   = 3,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [24:0]      s_a,
  input  logic signed [17:0]      s_b,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic [29:0]             dsp_a,
  output logic [17:0]             dsp_b,
  output logic [6:0]              dsp_opmode,
  output logic [3:0]              dsp_alumode,
  output logic [2:0]              dsp_carryinsel,
  output logic                    dsp_carryin,
  output logic                    dsp_ce,
  output logic                    dsp_rst,
  input  logic [47:0]             dsp_p,
  output logic [OUT_W-1:0]        m_data,
  output logic [CNT_W-1:0]        m_count,
  output logic                    m_ovf,
  output logic                    m_valid,
  input  logic                    m_ready
);

  localparam logic [6:0] OPMODE_LOAD  = 7'b000_0101;
  localparam logic [6:0] OPMODE_ACCUM = 7'b010_0101;
  localparam logic [6:0] OPMODE_HOLD  = 7'b010_0000;

  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } tag_t;

  // tag_q[0] is stage 1; tag_q[LAT-1] lines up with the value on dsp_p.
  tag_t [LAT-1:0]   tag_q;
  tag_t             tag_in;
  tag_t             tag_l;
  logic             first_pending;
  logic             dsp_rst_reg;
  logic [6:0]       opmode_reg;
  logic [CNT_W-1:0] cnt_p;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] count_next;
  logic             stall;
  logic             accept;
  logic             capture;
  logic [OUT_W-1:0] conv_data;
  logic             conv_ovf;
  logic [6:0]       opmode_next;

  assign tag_l   = tag_q[LAT-1];
  assign stall   = tag_l.v & tag_l.last & m_valid & ~m_ready;
  assign capture = tag_l.v & tag_l.last & (~m_valid | m_ready);
  assign dsp_ce  = ~stall;
  assign s_ready = ~stall & ~dsp_rst_reg;
  assign accept  = s_valid & s_ready;
  assign dsp_rst = dsp_rst_reg;

  assign dsp_a          = {{5{s_a[24]}}, s_a};
  assign dsp_b          = s_b;
  assign dsp_opmode     = opmode_reg;
  assign dsp_alumode    = 4'b0000;
  assign dsp_carryinsel = 3'b000;
  assign dsp_carryin    = 1'b0;

  always_comb begin
    tag_in.v     = accept;
    tag_in.first = first_pending;
    tag_in.last  = s_last;
  end

  always_comb begin
    opmode_next = OPMODE_HOLD;
    if (accept) begin
      opmode_next = first_pending ? OPMODE_LOAD : OPMODE_ACCUM;
    end
  end

  // A first term restarts the count even if the previous capture has not cleared cnt_p yet.
  always_comb begin
    cnt_base   = tag_l.first ? '0 : cnt_p;
    count_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_rst_reg <= 1'b1;
    end else begin
      dsp_rst_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q         <= '0;
      opmode_reg    <= OPMODE_HOLD;
      first_pending <= 1'b1;
    end else if (dsp_ce) begin
      tag_q      <= {tag_q[LAT-2:0], tag_in};
      opmode_reg <= opmode_next;
      if (accept) begin
        first_pending <= s_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p <= '0;
    end else if (capture) begin
      cnt_p <= '0;
    end else if (dsp_ce && tag_l.v) begin
      cnt_p <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_count <= '0;
    end else if (capture) begin
      m_valid <= 1'b1;
      m_data  <= conv_data;
      m_count <= count_next;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

`ifdef DSP_MAC_SAT_EN
  localparam logic signed [47:0] SAT_MAX = (48'sd1 <<< (OUT_W - 1)) - 48'sd1;
  localparam logic signed [47:0] SAT_MIN = -(48'sd1 <<< (OUT_W - 1));

  logic m_ovf_reg;

  always_comb begin
    conv_data = dsp_p[OUT_W-1:0];
    conv_ovf  = 1'b0;
    if ($signed(dsp_p) > SAT_MAX) begin
      conv_data = SAT_MAX[OUT_W-1:0];
      conv_ovf  = 1'b1;
    end else if ($signed(dsp_p) < SAT_MIN) begin
      conv_data = SAT_MIN[OUT_W-1:0];
      conv_ovf  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ovf_reg <= 1'b0;
    end else if (capture) begin
      m_ovf_reg <= conv_ovf;
    end
  end

  assign m_ovf = m_ovf_reg;
`else
  logic unused_p_bits;

  always_comb begin
    conv_data = dsp_p[OUT_W-1:0];
    conv_ovf  = 1'b0;
  end

  // Upper P bits are simply dropped when truncating.
  assign unused_p_bits = ^{dsp_p, conv_ovf};
  assign m_ovf         = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural DSP48E1 MAC slice model.
module tb_dsp_mac_sequencer;

  localparam int LAT   = 3;
  localparam int OUT_W = 16;
  localparam int CNT_W = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic signed [24:0]      s_a = '0;
  logic signed [17:0]      s_b = '0;
  logic                    s_valid = 1'b0;
  logic                    s_last = 1'b0;
  logic                    s_ready;
  logic [29:0]             dsp_a;
  logic [17:0]             dsp_b;
  logic [6:0]              dsp_opmode;
  logic [3:0]              dsp_alumode;
  logic [2:0]              dsp_carryinsel;
  logic                    dsp_carryin;
  logic                    dsp_ce;
  logic                    dsp_rst;
  logic [47:0]             dsp_p;
  logic [OUT_W-1:0]        m_data;
  logic [CNT_W-1:0]        m_count;
  logic                    m_ovf;
  logic                    m_valid;
  logic                    m_ready = 1'b0;

  dsp_mac_sequencer #(.LAT(LAT), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_a(s_a), .s_b(s_b), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_alumode(dsp_alumode),
    .dsp_carryinsel(dsp_carryinsel), .dsp_carryin(dsp_carryin), .dsp_ce(dsp_ce),
    .dsp_rst(dsp_rst), .dsp_p(dsp_p),
    .m_data(m_data), .m_count(m_count), .m_ovf(m_ovf), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Slice model: A/B register, M register, OPMODE register, P register.
  logic [29:0]        a_r = '0;
  logic signed [17:0] b_r = '0;
  logic signed [47:0] m_r = '0;
  logic signed [47:0] p_r = '0;
  logic [6:0]         op_r = '0;

  always @(posedge clk) begin
    if (dsp_rst) begin
      a_r <= '0; b_r <= '0; m_r <= '0; p_r <= '0; op_r <= '0;
    end else if (dsp_ce) begin
      a_r  <= dsp_a;
      b_r  <= dsp_b;
      m_r  <= $signed(a_r[24:0]) * b_r;
      op_r <= dsp_opmode;
      case (op_r)
        7'b000_0101: p_r <= m_r;
        7'b010_0101: p_r <= p_r + m_r;
        default:     p_r <= p_r;
      endcase
    end
  end
  assign dsp_p = p_r;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [OUT_W-1:0] q_data[$];
  logic [CNT_W-1:0] q_count[$];
  logic             q_ovf[$];
  int               q_cyc[$];

  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      q_data.push_back(m_data);
      q_count.push_back(m_count);
      q_ovf.push_back(m_ovf);
      q_cyc.push_back(cyc);
      $display("result data=%0h count=%0d ovf=%0b cycle=%0d", m_data, m_count, m_ovf, cyc);
    end
  end

  int checks = 0;
  int errors = 0;
  int last_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int a, input int b, input logic last);
    int n;
    n = 0;
    s_a = a[24:0];
    s_b = b[17:0];
    s_valid = 1'b1;
    s_last = last;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    if (!s_ready) chk("send_timeout", 64'd0, 64'd1);
    if (last) last_cyc = cyc;
    tick();
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic expect_res(input string tag, input logic [OUT_W-1:0] d, input logic [CNT_W-1:0] c,
                            input logic o, output int rc);
    rc = -1;
    if (q_data.size() == 0) begin
      chk({tag, "_missing"}, 64'd0, 64'd1);
    end else begin
      chk({tag, "_data"}, 64'(q_data.pop_front()), 64'(d));
      chk({tag, "_count"}, 64'(q_count.pop_front()), 64'(c));
      chk({tag, "_ovf"}, 64'(q_ovf.pop_front()), 64'(o));
      rc = q_cyc.pop_front();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int rc1, rc2, l1, l2;

    // Reset state
    tick();
    tick();
    s_a = -25'sd3;
    s_b = -18'sd7;
    #1;
    chk("rst_dsp_rst", 64'(dsp_rst), 64'd1);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_count", 64'(m_count), 64'd0);
    chk("rst_m_ovf", 64'(m_ovf), 64'd0);
    chk("rst_opmode", 64'(dsp_opmode), 64'h20);
    chk("rst_ce", 64'(dsp_ce), 64'd1);
    chk("const_alumode", 64'({dsp_alumode, dsp_carryinsel, dsp_carryin}), 64'd0);
    chk("dsp_a_sext", 64'(dsp_a), 64'h3FFF_FFFD);
    chk("dsp_b_pass", 64'(dsp_b), 64'h3FFF9);
    rst_n = 1'b1;
    #1;
    chk("rel_dsp_rst_hold", 64'(dsp_rst), 64'd1);
    tick();
    chk("rel_dsp_rst_low", 64'(dsp_rst), 64'd0);
    chk("rel_s_ready", 64'(s_ready), 64'd1);
    m_ready = 1'b1;

    // Basic vector: 12 - 10 + 42 = 44
    send(3, 4, 1'b0);
    send(5, -2, 1'b0);
    send(7, 6, 1'b1);
    l1 = last_cyc;
    repeat (10) tick();
    chk("basic_nres", 64'(q_data.size()), 64'd1);
    expect_res("basic", 16'd44, 16'd3, 1'b0, rc1);
    chk("basic_latency", 64'(rc1 - l1), 64'd4);

    // Same terms with two idle cycles between each
    send(3, 4, 1'b0);
    repeat (2) tick();
    send(5, -2, 1'b0);
    repeat (2) tick();
    send(7, 6, 1'b1);
    repeat (10) tick();
    chk("gaps_nres", 64'(q_data.size()), 64'd1);
    expect_res("gaps", 16'd44, 16'd3, 1'b0, rc1);

    // Back-to-back vectors
    send(2, 2, 1'b1);
    l1 = last_cyc;
    send(1, 1, 1'b0);
    send(-1, 1, 1'b1);
    l2 = last_cyc;
    repeat (10) tick();
    chk("b2b_nres", 64'(q_data.size()), 64'd2);
    expect_res("b2b_v1", 16'd4, 16'd1, 1'b0, rc1);
    expect_res("b2b_v2", 16'd0, 16'd2, 1'b0, rc2);
    chk("b2b_lat1", 64'(rc1 - l1), 64'd4);
    chk("b2b_lat2", 64'(rc2 - l2), 64'd4);

    // Backpressure: 6 is held, 21 waits in the slice
    m_ready = 1'b0;
    send(2, 3, 1'b1);
    send(4, 5, 1'b0);
    send(1, 1, 1'b1);
    repeat (6) tick();
    chk("bp_m_valid", 64'(m_valid), 64'd1);
    chk("bp_m_data", 64'(m_data), 64'd6);
    chk("bp_m_count", 64'(m_count), 64'd1);
    chk("bp_ce", 64'(dsp_ce), 64'd0);
    chk("bp_s_ready", 64'(s_ready), 64'd0);
    chk("bp_opmode_hold", 64'(dsp_opmode), 64'h20);
    tick();
    chk("bp_m_data_stable", 64'(m_data), 64'd6);
    m_ready = 1'b1;
    tick();
    chk("bp_next_valid", 64'(m_valid), 64'd1);
    chk("bp_next_data", 64'(m_data), 64'd21);
    chk("bp_ce_resume", 64'(dsp_ce), 64'd1);
    repeat (4) tick();
    chk("bp_nres", 64'(q_data.size()), 64'd2);
    expect_res("bp_v1", 16'd6, 16'd1, 1'b0, rc1);
    expect_res("bp_v2", 16'd21, 16'd2, 1'b0, rc2);
    chk("bp_consecutive", 64'(rc2 - rc1), 64'd1);

    // Reset in the middle of a vector
    send(9, 9, 1'b0);
    send(8, 8, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_dsp_rst", 64'(dsp_rst), 64'd1);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_opmode", 64'(dsp_opmode), 64'h20);
    tick();
    rst_n = 1'b1;
    tick();
    send(1, 1, 1'b1);
    repeat (10) tick();
    chk("mid_rst_nres", 64'(q_data.size()), 64'd1);
    expect_res("mid_rst", 16'd1, 16'd1, 1'b0, rc1);

    // Large positive sum, low 16 bits = 2
    send(16777215, 131071, 1'b0);
    send(1, 1, 1'b1);
    repeat (10) tick();
`ifdef DSP_MAC_SAT_EN
    expect_res("sat_pos", 16'h7FFF, 16'd2, 1'b1, rc1);
`else
    expect_res("trunc_pos", 16'h0002, 16'd2, 1'b0, rc1);
`endif
    // Large negative product, low 16 bits = 0
    send(-16777216, 131071, 1'b1);
    repeat (10) tick();
`ifdef DSP_MAC_SAT_EN
    expect_res("sat_neg", 16'h8000, 16'd1, 1'b1, rc1);
`else
    expect_res("trunc_neg", 16'h0000, 16'd1, 1'b0, rc1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
